// File: rtl/pe_fc_pkg.sv
// Shared types, default widths and the round/saturate helper for the
// vector fully-connected processing element.
package pe_fc_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_LANES      = 4;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_ACC_WIDTH  = 48;

  // Container width for the round/saturate helper; any ACC_WIDTH up to
  // this fits after sign extension.
  localparam int RS_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [RS_W-1:0] value;
    logic            sat;
  } round_sat_t;

  // Round half toward +inf, arithmetic shift, then clip to a signed
  // data_width range. acc arrives sign-extended to RS_W bits.
  function automatic round_sat_t round_sat(
    input logic signed [RS_W-1:0] acc,
    input int unsigned            data_width,
    input int unsigned            frac_bits
  );
    round_sat_t              res;
    logic signed [RS_W-1:0]  half;
    logic signed [RS_W-1:0]  r;
    logic signed [RS_W-1:0]  hi;
    logic signed [RS_W-1:0]  lo;
    half = (frac_bits == 0) ? 64'sd0 : (64'sd1 <<< (frac_bits - 1));
    r    = (acc + half) >>> frac_bits;
    hi   = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (data_width - 1));
    res.sat   = 1'b0;
    res.value = r;
    if (r > hi) begin
      res.sat   = 1'b1;
      res.value = hi;
    end else if (r < lo) begin
      res.sat   = 1'b1;
      res.value = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_fc_mac_vec_lane_dot.sv
// LANES signed multipliers (stage 1) feeding a registered adder tree
// (stage 2); a valid bit travels with each stage so bubbles stay bubbles.
module pe_fc_lane_dot
  import pe_fc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int SUM_W      = 2 * DATA_WIDTH + $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [LANES*DATA_WIDTH-1:0]   in_weight,
  output logic                          pipe_active,
  output logic                          sum_valid,
  output logic signed [SUM_W-1:0]       sum
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic                     s1_valid;
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [SUM_W-1:0]  sum_c;

  // NOTE: a combinational block assigns every output a default first and
  // uses blocking '=' so the running sum reads its own previous value
  // within the same pass; no latch is inferred.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + SUM_W'(prod_q[i]);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers sample
  // pre-edge values. The product array is a handful of pipeline registers,
  // not a memory, so it is cheap to clear and keeps out_acc deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      sum_valid <= 1'b0;
      sum       <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      s1_valid  <= in_valid;
      sum_valid <= s1_valid;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[i] <= PROD_W'(signed'(in_data[i*DATA_WIDTH +: DATA_WIDTH])) *
                       PROD_W'(signed'(in_weight[i*DATA_WIDTH +: DATA_WIDTH]));
        end
      end
      if (s1_valid) begin
        sum <= sum_c;
      end
    end
  end

  assign pipe_active = s1_valid || sum_valid;

endmodule

// File: rtl/pe_fc_mac_vec.sv
// Vector fully-connected PE: streams LANES-wide beats into a bias-seeded
// accumulator, then rounds, saturates and optionally rectifies one output.
module pe_fc_mac_vec
  import pe_fc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int LANES      = DEF_LANES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_W-1:0]            num_beats,
  input  logic [DATA_WIDTH-1:0]       bias,
  input  logic                        relu_en,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [LANES*DATA_WIDTH-1:0] in_weight,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_sat,
  output logic [ACC_WIDTH-1:0]        out_acc
);

  localparam int SUM_W = 2 * DATA_WIDTH + $clog2(LANES);

  if (ACC_WIDTH < SUM_W + CNT_W || ACC_WIDTH > RS_W) begin : g_bad_acc_width
    $error("pe_fc_mac_vec: ACC_WIDTH out of range");
  end

  state_t                     state;
  logic [CNT_W-1:0]           beats_q;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       relu_q;
  logic signed [ACC_WIDTH-1:0] acc;
  // Set for one cycle after each accumulator write, so the result is only
  // taken once the accumulate stage has settled.
  logic                       acc_pending;

  logic                       beat_fire;
  logic                       pipe_active;
  logic                       sum_valid;
  logic signed [SUM_W-1:0]    lane_sum;
  logic                       pipe_empty;

  round_sat_t                 rs;
  logic [DATA_WIDTH-1:0]      res_data;
  logic                       res_neg;
  logic                       unused_rs_hi;

  assign beat_fire = in_valid && in_ready;

  pe_fc_lane_dot #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .SUM_W      (SUM_W)
  ) u_lane_dot (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (beat_fire),
    .in_data     (in_data),
    .in_weight   (in_weight),
    .pipe_active (pipe_active),
    .sum_valid   (sum_valid),
    .sum         (lane_sum)
  );

  assign pipe_empty   = !pipe_active && !acc_pending;
  assign rs           = round_sat(RS_W'(acc), DATA_WIDTH, FRAC_BITS);
  assign res_data     = rs.value[DATA_WIDTH-1:0];
  assign res_neg      = res_data[DATA_WIDTH-1];
  assign unused_rs_hi = ^rs.value[RS_W-1:DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_sat     <= 1'b0;
      out_data    <= '0;
      out_acc     <= '0;
      beats_q     <= '0;
      beat_cnt    <= '0;
      relu_q      <= 1'b0;
      acc         <= '0;
      acc_pending <= 1'b0;
    end else begin
      acc_pending <= sum_valid;
      if (sum_valid) begin
        acc <= acc + ACC_WIDTH'(lane_sum);
      end

      case (state)
        IDLE: begin
          if (start) begin
            beats_q     <= num_beats;
            relu_q      <= relu_en;
            beat_cnt    <= '0;
            acc         <= ACC_WIDTH'(signed'(bias)) <<< FRAC_BITS;
            acc_pending <= 1'b1;
            busy        <= 1'b1;
            if (num_beats == '0) begin
              state <= DRAIN;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == beats_q - CNT_W'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            out_data  <= (relu_q && res_neg) ? '0 : res_data;
            out_sat   <= rs.sat;
            out_acc   <= acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_fc_mac_vec.sv
// Directed bench for pe_fc_mac_vec with hand-computed Q8.8 results.
module tb_pe_fc_mac_vec;

  localparam int DW    = 16;
  localparam int FB    = 8;
  localparam int LANES = 4;
  localparam int CNT_W = 10;
  localparam int ACC_W = 48;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [CNT_W-1:0]      num_beats;
  logic [DW-1:0]         bias;
  logic                  relu_en;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [LANES*DW-1:0]   in_weight;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic                  out_sat;
  logic [ACC_W-1:0]      out_acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_fc_mac_vec #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .LANES      (LANES),
    .CNT_W      (CNT_W),
    .ACC_WIDTH  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_beats (num_beats),
    .bias      (bias),
    .relu_en   (relu_en),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_acc   (out_acc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*DW-1:0] splat(input logic [DW-1:0] v);
    logic [LANES*DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_job(input int nb, input logic [DW-1:0] b, input logic relu);
    start     = 1'b1;
    num_beats = CNT_W'(nb);
    bias      = b;
    relu_en   = relu;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one beat and returns at the negedge after its accept edge.
  task automatic send_beat(input logic [LANES*DW-1:0] x, input logic [LANES*DW-1:0] w,
                           input int gap);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid  = 1'b1;
    in_data   = x;
    in_weight = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    repeat (gap) @(negedge clk);
  endtask

  // Counts rising edges until out_valid is seen; in_ready must stay low.
  task automatic wait_result(input string tag, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      check({tag, "_in_ready_low"}, in_ready, 0);
    end while (!out_valid && edges < 40);
    if (!out_valid) check({tag, "_out_valid_timeout"}, 0, 1);
  endtask

  task automatic finish_job(input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_out_valid"}, out_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int e;
    logic [LANES*DW-1:0] xv;
    logic [LANES*DW-1:0] wv;

    rst_n = 1'b0; start = 1'b0; num_beats = '0; bias = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_acc", out_acc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat: 4 lanes of 1.0*2.0 = 8.0
    start_job(1, 16'h0000, 1'b0);
    check("single_busy", busy, 1);
    check("single_in_ready", in_ready, 1);
    send_beat(splat(16'h0100), splat(16'h0200), 0);
    wait_result("single", e);
    check("single_latency", e, 4);
    check("single_data", out_data, 16'h0800);
    check("single_sat", out_sat, 0);
    check("single_acc", out_acc, 48'h80000);
    finish_job("single");

    // Gapped stream: 3 beats of 4.0 plus bias 0.5 = 12.5
    start_job(3, 16'h0080, 1'b0);
    send_beat(splat(16'h0100), splat(16'h0100), 2);
    send_beat(splat(16'h0100), splat(16'h0100), 2);
    send_beat(splat(16'h0100), splat(16'h0100), 0);
    wait_result("gap", e);
    check("gap_latency", e, 4);
    check("gap_data", out_data, 16'h0C80);
    check("gap_sat", out_sat, 0);
    check("gap_acc", out_acc, 48'hC8000);
    finish_job("gap");

    // Distinct lanes: 1*1 + 2*1 + (-1)*1 + 0.5*2 = 3.0
    xv = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};
    wv = {16'h0200, 16'h0100, 16'h0100, 16'h0100};
    start_job(1, 16'h0000, 1'b0);
    send_beat(xv, wv, 0);
    wait_result("lanes", e);
    check("lanes_data", out_data, 16'h0300);
    check("lanes_sat", out_sat, 0);
    finish_job("lanes");

    // Positive saturation
    start_job(2, 16'h0000, 1'b0);
    send_beat(splat(16'h7FFF), splat(16'h7FFF), 0);
    send_beat(splat(16'h7FFF), splat(16'h7FFF), 0);
    wait_result("satp", e);
    check("satp_data", out_data, 16'h7FFF);
    check("satp_sat", out_sat, 1);
    check("satp_acc", out_acc, 48'h1_FFF8_0008);
    finish_job("satp");

    // Negative saturation
    start_job(2, 16'h0000, 1'b0);
    send_beat(splat(16'h8000), splat(16'h7FFF), 0);
    send_beat(splat(16'h8000), splat(16'h7FFF), 0);
    wait_result("satn", e);
    check("satn_data", out_data, 16'h8000);
    check("satn_sat", out_sat, 1);
    finish_job("satn");

    // Bias only, -1.0, without and with ReLU
    start_job(0, 16'hFF00, 1'b0);
    check("bias_in_ready", in_ready, 0);
    wait_result("bias", e);
    check("bias_latency", e, 2);
    check("bias_data", out_data, 16'hFF00);
    check("bias_sat", out_sat, 0);
    finish_job("bias");

    start_job(0, 16'hFF00, 1'b1);
    wait_result("relu", e);
    check("relu_latency", e, 2);
    check("relu_data", out_data, 16'h0000);
    check("relu_sat", out_sat, 0);
    finish_job("relu");

    // Backpressure in DONE with ignored start pulses
    out_ready = 1'b0;
    start_job(1, 16'h0000, 1'b0);
    send_beat(splat(16'h0100), splat(16'h0200), 0);
    wait_result("bp", e);
    num_beats = '0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 2 || i == 5);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 16'h0800);
      check("bp_busy", busy, 1);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    finish_job("bp");
    @(negedge clk);
    check("bp_no_queued_start", busy, 0);

    // Reset mid-job, then a clean single-beat job
    start_job(5, 16'h0000, 1'b0);
    send_beat(splat(16'h0100), splat(16'h0100), 0);
    send_beat(splat(16'h0100), splat(16'h0100), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_sat", out_sat, 0);
    check("mid_rst_out_acc", out_acc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(1, 16'h0000, 1'b0);
    send_beat(splat(16'h0100), splat(16'h0200), 0);
    wait_result("after_rst", e);
    check("after_rst_latency", e, 4);
    check("after_rst_data", out_data, 16'h0800);
    check("after_rst_acc", out_acc, 48'h80000);
    finish_job("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
